alu_selftest_ctrl: RTL
======================

ALU_SELFTEST_CTRL -- requirements
Module: alu_selftest_ctrl

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 1024: cycles between self-test attempts.
REQ-002 SHALL have parameter MISMATCH_LIMIT, default 2: consecutive failed runs before fault is forced.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pipe_idle  input  1  high when the execute stage holds no valid instruction this cycle.
REQ-006 pipe_A, pipe_B  input  32 each  operands from decode/issue.
REQ-007 pipe_ctrl  input  3  ALU control from decode.
REQ-008 alu_A, alu_B  output  32 each  operands driven into the fault-tolerant ALU.
REQ-009 alu_ctrl  output  3  ALU control driven into the fault-tolerant ALU.
REQ-010 alu_result  input  32  ALU Result.
REQ-011 alu_zero, alu_negative  input  1 each  ALU Zero/Negative flags.
REQ-012 fault_detected_in  input  1  high once the ALU has switched to its spare.
REQ-013 force_alu_fault  output  1  one-cycle pulse requesting switchover to spare.
REQ-014 test_active  output  1  high while test vectors own the ALU inputs.
REQ-015 pass_cnt  output  8  count of completed passing runs.
REQ-016 err_cnt  output  2  count of consecutive failing runs.

Function
REQ-017 alu_A/alu_B/alu_ctrl SHALL equal pipe_A/pipe_B/pipe_ctrl when test_active=0 and current vector when test_active=1, combinationally.
REQ-018 Vector ROM SHALL hold 4 entries {A,B,ctrl,expected Result,Z,N}: V0 5+3 ctrl 000 -> 0x00000008,Z0,N0; V1 5-5 ctrl 001 -> 0x00000000,Z1,N0; V2 0xFFFF0000 & 0x0F0F0F0F ctrl 010 -> 0x0F0F0000,Z0,N0; V3 0x00000001-0x00000002 ctrl 001 -> 0xFFFFFFFF,Z0,N1.
REQ-019 Carry and OverFlow SHALL NOT be checked.
REQ-020 FSM states SHALL be WAIT, ARM, RUN, FAULT, HALT.
REQ-021 WAIT: period counter increments each cycle; at SCAN_PERIOD-1 counter clears and FSM -> ARM.
REQ-022 ARM: stays until pipe_idle=1, then -> RUN with vector index 0.
REQ-023 RUN: test_active=1; one vector per cycle; at each rising edge result and flags compared against expected and a sticky run-mismatch bit updated; index increments.
REQ-024 RUN: if pipe_idle=0 in any cycle, that cycle's compare SHALL be discarded, run aborted without verdict, sticky bit cleared, FSM -> ARM (restart at V0).
REQ-025 Run ends after V3 compare: pass -> err_cnt cleared, pass_cnt +1 saturating at 255, -> WAIT; fail -> err_cnt +1, -> FAULT if new err_cnt = MISMATCH_LIMIT else WAIT.
REQ-026 FAULT: force_alu_fault=1 for exactly one cycle, then -> HALT.
REQ-027 HALT: terminal until reset; test_active=0; no further runs.
REQ-028 fault_detected_in=1 in any state except FAULT SHALL send FSM to HALT next cycle; a RUN in progress is aborted without verdict.
REQ-029 force_alu_fault SHALL be 0 in every state except FAULT.
REQ-030 err_cnt SHALL saturate at 3.

Reset
REQ-031 rst=0 at a rising edge SHALL set state WAIT, period counter 0, vector index 0, sticky bit 0, pass_cnt 0, err_cnt 0; force_alu_fault=0, test_active=0.
REQ-032 Reset SHALL take priority over all events, including mid-RUN and FAULT.

Verification
REQ-033 SCAN_PERIOD=16, pipe_idle=1, ALU correct -> test_active high cycles 17..20 after reset release, pass_cnt=1, err_cnt=0, force_alu_fault never high.
REQ-034 ALU stuck Result=0x00000000, MISMATCH_LIMIT=2 -> err_cnt 1 after first run, single-cycle force_alu_fault after second run, then HALT, test_active stays 0.
REQ-035 pipe_idle dropped at V2 of a run -> test_active falls next cycle, alu_A follows pipe_A, no pass_cnt/err_cnt change, run restarts at V0 when pipe_idle returns.
REQ-036 One failing run then one passing run -> err_cnt 1 then 0, no fault pulse.
REQ-037 fault_detected_in raised during WAIT -> HALT next cycle, no further test_active.
REQ-038 rst=0 during RUN at V1 -> all outputs at reset values next cycle; period restarts from 0.

Source files
------------

// File: rtl/alu_selftest_ctrl.sv
// Periodic built-in self-test of the fault-tolerant ALU, using idle execute-stage cycles.
// Latency: one vector per cycle while idle; repeated failing runs request a switchover to the spare ALU.
module alu_selftest_ctrl #(
    parameter int SCAN_PERIOD    = 1024,
    parameter int MISMATCH_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_idle,
    input  logic [31:0] pipe_A,
    input  logic [31:0] pipe_B,
    input  logic [2:0]  pipe_ctrl,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        fault_detected_in,
    output logic        force_alu_fault,
    output logic        test_active,
    output logic [7:0]  pass_cnt,
    output logic [1:0]  err_cnt
);

    localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    typedef enum logic [2:0] {WAIT, ARM, RUN, FAULT, HALT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [1:0]    vec_idx_q, vec_idx_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    pass_cnt_q, pass_cnt_d;
    logic [1:0]    err_cnt_q, err_cnt_d;

    logic [31:0] vec_a, vec_b, vec_res;
    logic [2:0]  vec_ctrl;
    logic        vec_z, vec_n;
    logic        mismatch, run_fail;
    logic [1:0]  err_inc;

    // Carry and overflow are deliberately not part of the vector set.
    always_comb begin
        vec_a = 32'd5; vec_b = 32'd3; vec_ctrl = 3'b000;
        vec_res = 32'h0000_0008; vec_z = 1'b0; vec_n = 1'b0;
        case (vec_idx_q)
            2'd0: begin
                vec_a = 32'd5; vec_b = 32'd3; vec_ctrl = 3'b000;
                vec_res = 32'h0000_0008; vec_z = 1'b0; vec_n = 1'b0;
            end
            2'd1: begin
                vec_a = 32'd5; vec_b = 32'd5; vec_ctrl = 3'b001;
                vec_res = 32'h0000_0000; vec_z = 1'b1; vec_n = 1'b0;
            end
            2'd2: begin
                vec_a = 32'hFFFF_0000; vec_b = 32'h0F0F_0F0F; vec_ctrl = 3'b010;
                vec_res = 32'h0F0F_0000; vec_z = 1'b0; vec_n = 1'b0;
            end
            default: begin
                vec_a = 32'h0000_0001; vec_b = 32'h0000_0002; vec_ctrl = 3'b001;
                vec_res = 32'hFFFF_FFFF; vec_z = 1'b0; vec_n = 1'b1;
            end
        endcase
    end

    assign test_active     = (state_q == RUN);
    assign force_alu_fault = (state_q == FAULT);
    assign alu_A           = test_active ? vec_a    : pipe_A;
    assign alu_B           = test_active ? vec_b    : pipe_B;
    assign alu_ctrl        = test_active ? vec_ctrl : pipe_ctrl;
    assign pass_cnt        = pass_cnt_q;
    assign err_cnt         = err_cnt_q;

    assign mismatch = (alu_result != vec_res) || (alu_zero != vec_z) || (alu_negative != vec_n);
    assign run_fail = sticky_q | mismatch;
    assign err_inc  = (err_cnt_q == 2'd3) ? 2'd3 : err_cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = '0;
        vec_idx_d  = vec_idx_q;
        sticky_d   = sticky_q;
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            WAIT: begin
                if (fault_detected_in) begin
                    state_d = HALT;
                end else if (per_cnt_q == PW'(SCAN_PERIOD - 1)) begin
                    state_d = ARM;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            ARM: begin
                vec_idx_d = 2'd0;
                sticky_d  = 1'b0;
                if (fault_detected_in) state_d = HALT;
                else if (pipe_idle)    state_d = RUN;
            end
            RUN: begin
                // A busy pipeline or a detected fault abandons the run with no verdict.
                if (fault_detected_in || !pipe_idle) begin
                    state_d   = fault_detected_in ? HALT : ARM;
                    vec_idx_d = 2'd0;
                    sticky_d  = 1'b0;
                end else if (vec_idx_q == 2'd3) begin
                    vec_idx_d = 2'd0;
                    sticky_d  = 1'b0;
                    if (run_fail) begin
                        err_cnt_d = err_inc;
                        state_d   = (int'(err_inc) == MISMATCH_LIMIT) ? FAULT : WAIT;
                    end else begin
                        err_cnt_d = 2'd0;
                        if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
                        state_d = WAIT;
                    end
                end else begin
                    vec_idx_d = vec_idx_q + 2'd1;
                    sticky_d  = run_fail;
                end
            end
            FAULT:   state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WAIT;
            per_cnt_q  <= '0;
            vec_idx_q  <= 2'd0;
            sticky_q   <= 1'b0;
            pass_cnt_q <= 8'd0;
            err_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            vec_idx_q  <= vec_idx_d;
            sticky_q   <= sticky_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
